// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one request in flight, byte-addressed little-endian
// storage, configurable latency, misalignment reported in the response.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 1 << DM_ADDRESS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [1:0]              size_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;
  logic [7:0]              mem_q [DEPTH];

  logic [DM_ADDRESS-1:0]   a0, a1, a2, a3;
  logic                    err_d;
  logic                    finish_d;
  logic [31:0]             ld_word;
  logic [31:0]             st_word;
  logic [DATA_W-1:0]       rdata_d;

  // Size 3 is handled exactly like a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd1:    return lsb[0];
      2'd2:    return 1'b0;
      default: return lsb != 2'b00;
    endcase
  endfunction

  assign a0       = addr_q;
  assign a1       = addr_q + DM_ADDRESS'(1);
  assign a2       = addr_q + DM_ADDRESS'(2);
  assign a3       = addr_q + DM_ADDRESS'(3);
  assign err_d    = misaligned(size_q, addr_q[1:0]);
  assign finish_d = (state_q == BUSY) && (cnt_q == 4'd0);
  assign st_word  = 32'(wdata_q);

  always_comb begin
    ld_word = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
    case (size_q)
      2'd2:    ld_word = {24'd0, mem_q[a0]};
      2'd1:    ld_word = {16'd0, mem_q[a1], mem_q[a0]};
      default: ;
    endcase
    rdata_d = (wr_q || err_d) ? '0 : DATA_W'(ld_word);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a store lands only on the BUSY->RESP edge, so an
  // asynchronous reset during BUSY drops it by forcing the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (finish_d && wr_q && !err_d) begin
      mem_q[a0] <= st_word[7:0];
      if (size_q != 2'd2) mem_q[a1] <= st_word[15:8];
      if (size_q == 2'd0 || size_q == 2'd3) begin
        mem_q[a2] <= st_word[23:16];
        mem_q[a3] <= st_word[31:24];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: latency-stamped transaction model with a byte-array
// memory, checked every cycle, plus literal expectations and a zero-wait instance.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_valid = 1'b0, z_write = 1'b0, z_rready = 1'b0;
  logic [8:0]  z_addr = '0;
  logic [1:0]  z_size = '0;
  logic [31:0] z_wdata = '0;
  logic        z_ready, z_rvalid, z_err;
  logic [31:0] z_rdata;

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
    .req_addr(z_addr), .req_size(z_size), .req_wdata(z_wdata),
    .resp_valid(z_rvalid), .resp_ready(z_rready),
    .resp_rdata(z_rdata), .resp_err(z_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mm [512];
  logic        m_pend = 1'b0, m_resp = 1'b0, m_wr = 1'b0, m_err = 1'b0;
  logic [8:0]  m_addr = '0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  int unsigned edge_n = 0, m_due = 0;

  function automatic logic is_mis(input logic [1:0] s, input logic [8:0] a);
    return (s == 2'd1 && a[0]) || ((s == 2'd0 || s == 2'd3) && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd2) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pend = 1'b0; m_resp = 1'b0; m_rdata = '0; m_err = 1'b0;
    end else begin
      edge_n++;
      if (m_resp) begin
        if (resp_ready) m_resp = 1'b0;
      end else if (m_pend) begin
        if (edge_n == m_due) begin
          m_err   = is_mis(m_size, m_addr);
          m_rdata = '0;
          if (!m_err) begin
            for (int k = 0; k < nbytes(m_size); k++) begin
              logic [8:0] ak;
              ak = m_addr + 9'(k);
              if (m_wr) mm[ak] = m_wdata[8*k +: 8];
              else      m_rdata[8*k +: 8] = mm[ak];
            end
          end
          m_pend = 1'b0;
          m_resp = 1'b1;
        end
      end else if (req_valid) begin
        m_wr = req_write; m_addr = req_addr; m_size = req_size; m_wdata = req_wdata;
        m_due = edge_n + W + 1;
        m_pend = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (rst_n) chk("req_ready", 32'(req_ready), 32'(!m_pend && !m_resp));
      chk("resp_valid", 32'(resp_valid), 32'(m_resp));
      if (m_resp || !rst_n) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input logic wr, input logic [8:0] a, input logic [1:0] s,
                     input logic [31:0] wd, input int hold, input logic poke,
                     output logic [31:0] rd, output logic er, output int lat);
    int   guard;
    logic rdy;
    rd = '0; er = 1'b0; lat = 0;
    req_write = wr; req_addr = a; req_size = s; req_wdata = wd; req_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); guard++;
    end while (!rdy && guard < 50);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom; req_addr = 9'($urandom); req_size = 2'($urandom); req_write = ~wr;
    if (!rdy) begin chk("accept_timeout", 32'd0, 32'd1); return; end
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!resp_valid) begin chk("resp_timeout", 32'd0, 32'd1); return; end
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        wr;
    logic [1:0]  s;
    logic [8:0]  a;
    logic        zr, zv;
    int          acc_e[$];
    int          hs_e[$];

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 128; i++) txn(1'b1, 9'(i * 4), 2'd0, $urandom, 0, 1'b0, rd, er, lat);

    txn(1'b1, 9'h010, 2'd0, 32'hDEADBEEF, 0, 1'b0, rd, er, lat);
    chk("st_word_latency", 32'(lat), 32'd4);
    chk("st_word_rdata", rd, 32'd0);
    chk("st_word_err", 32'(er), 32'd0);
    txn(1'b0, 9'h010, 2'd0, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld_word_latency", 32'(lat), 32'd4);
    chk("ld_word_rdata", rd, 32'hDEADBEEF);
    chk("ld_word_err", 32'(er), 32'd0);

    txn(1'b1, 9'h011, 2'd2, 32'hAAAAAA55, 0, 1'b0, rd, er, lat);
    txn(1'b0, 9'h010, 2'd0, 32'h0, 1, 1'b0, rd, er, lat);
    chk("ld_after_byte_st", rd, 32'hDEAD55EF);
    txn(1'b0, 9'h012, 2'd1, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld_half", rd, 32'h0000DEAD);
    txn(1'b0, 9'h013, 2'd2, 32'h0, 2, 1'b0, rd, er, lat);
    chk("ld_byte", rd, 32'h000000DE);

    txn(1'b1, 9'h020, 2'd0, 32'h0BADF00D, 0, 1'b0, rd, er, lat);
    txn(1'b1, 9'h021, 2'd1, 32'h0000FFFF, 0, 1'b0, rd, er, lat);
    chk("mis_st_err", 32'(er), 32'd1);
    chk("mis_st_latency", 32'(lat), 32'd4);
    txn(1'b0, 9'h022, 2'd0, 32'h0, 0, 1'b0, rd, er, lat);
    chk("mis_ld_err", 32'(er), 32'd1);
    chk("mis_ld_rdata", rd, 32'd0);
    txn(1'b0, 9'h020, 2'd0, 32'h0, 0, 1'b0, rd, er, lat);
    chk("word_020_unchanged", rd, 32'h0BADF00D);
    txn(1'b0, 9'h023, 2'd3, 32'h0, 0, 1'b0, rd, er, lat);
    chk("mis_size3_err", 32'(er), 32'd1);

    txn(1'b0, 9'h010, 2'd0, 32'h0, 5, 1'b1, rd, er, lat);
    chk("stall_rdata", rd, 32'hDEAD55EF);
    txn(1'b0, 9'h014, 2'd2, 32'h0, 0, 1'b0, rd, er, lat);

    for (int i = 0; i < 250; i++) begin
      wr = 1'($urandom_range(0, 1));
      s  = 2'($urandom);
      a  = 9'($urandom);
      if ($urandom_range(0, 3) != 0)
        a = (s == 2'd2) ? a : (s == 2'd1) ? {a[8:1], 1'b0} : {a[8:2], 2'b00};
      txn(wr, a, s, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), rd, er, lat);
      chk("latency", 32'(lat), 32'(W + 2));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    txn(1'b1, 9'h030, 2'd0, 32'hA5A5A5A5, 0, 1'b0, rd, er, lat);
    txn(1'b0, 9'h030, 2'd0, 32'h0, 0, 1'b0, rd, er, lat);
    chk("pre_reset_ld", rd, 32'hA5A5A5A5);
    req_write = 1'b1; req_addr = 9'h030; req_size = 2'd0; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(negedge clk);
    chk("rst_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 9'h030, 2'd0, 32'h0, 0, 1'b0, rd, er, lat);
    chk("dropped_store", rd, 32'hA5A5A5A5);
    chk("post_reset_latency", 32'(lat), 32'd4);

    z_write = 1'b1; z_addr = 9'h040; z_size = 2'd0; z_wdata = 32'hCAFEF00D;
    z_valid = 1'b1; z_rready = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      zr = z_ready; zv = z_rvalid;
      if (zv) begin
        chk("w0_st_rdata", z_rdata, 32'd0);
        chk("w0_st_err", 32'(z_err), 32'd0);
      end
      @(posedge clk);
      if (zr) acc_e.push_back(e);
      if (zv) hs_e.push_back(e);
    end
    #1 z_valid = 1'b0; z_rready = 1'b0;
    if (acc_e.size() >= 2 && hs_e.size() >= 1) begin
      chk("w0_accept_to_handshake", 32'(hs_e[0] - acc_e[0]), 32'd2);
      chk("w0_handshake_to_accept", 32'(acc_e[1] - hs_e[0]), 32'd1);
    end else begin
      chk("w0_sequence", 32'd0, 32'd1);
    end

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter DM_ADDRESS, default 9, byte-address width; storage is 2^DM_ADDRESS bytes, i.e. 128 words at default.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and response; legal range 0..15.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  initiator presents a request.
REQ-008 req_ready  out  1  responder can accept a request.
REQ-009 req_write  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  DM_ADDRESS  byte address.
REQ-011 req_size  in  2  access size: 0 = word, 1 = half, 2 = byte, 3 = treated as word.
REQ-012 req_wdata  in  DATA_W  store data, right-aligned.
REQ-013 resp_valid  out  1  response available.
REQ-014 resp_ready  in  1  initiator accepts the response.
REQ-015 resp_rdata  out  DATA_W  load data, right-aligned and zero-extended; the initiator performs sign extension.
REQ-016 resp_err  out  1  misaligned access.

Function
REQ-017 The FSM SHALL have three states (IDLE, BUSY, RESP) and SHALL drive req_ready=1 only in IDLE and resp_valid=1 only in RESP.
REQ-018 Accept: when req_valid && req_ready at a clock edge, the block SHALL capture write, addr, size and wdata into holding registers and enter BUSY.
REQ-019 BUSY wait counter:
- load WAIT_CYCLES on accept, decrement each cycle in BUSY;
- leave BUSY for RESP on the edge where the counter equals 0;
- with WAIT_CYCLES=0, the request spends 1 cycle in BUSY, so resp_valid asserts 2 edges after accept;
- general case: resp_valid asserts WAIT_CYCLES+2 edges after accept.
REQ-020 Store commit happens on the BUSY->RESP edge. Storage is little-endian bytes. Byte lanes written:
- word: lanes addr..addr+3;
- half: lanes addr, addr+1;
- byte: lane addr only.
Other bytes SHALL be unchanged.
REQ-021 Load data SHALL be sampled on the BUSY->RESP edge and held stable in resp_rdata throughout RESP:
- byte: {24'b0, byte[addr]};
- half: {16'b0, byte[addr+1], byte[addr]};
- word: bytes addr+3..addr.
REQ-022 Misaligned access (half with addr[0]=1, or word/size3 with addr[1:0]!=0) SHALL:
- set resp_err=1;
- suppress the store commit;
- return resp_rdata=0;
- still take the full WAIT_CYCLES latency.
REQ-023 Store responses SHALL return resp_rdata=0, and resp_err=0 when aligned.
REQ-024 In RESP, if resp_ready=1 at an edge the block SHALL return to IDLE; otherwise it SHALL hold RESP with all response outputs stable.
REQ-025 A request arriving while req_ready=0 SHALL be ignored; the initiator must hold it until it is accepted.
REQ-026 No back-to-back overlap: a new request can be accepted at the earliest one cycle after the response handshake.
REQ-027 Address arithmetic SHALL wrap modulo 2^DM_ADDRESS, though aligned accesses never wrap.
REQ-028 The counter SHALL be 4 bits wide.

Reset
REQ-029 On reset low, the block SHALL immediately force:
- state=IDLE, counter=0;
- holding registers, resp_rdata and resp_err=0;
- resp_valid=0, req_ready=1 after release.
REQ-030 Reset SHALL NOT clear the storage array.
REQ-031 Reset asserted during BUSY before the commit edge SHALL drop the pending store, leaving storage unmodified.
REQ-032 Reset deassertion SHALL take effect on the first rising edge with reset high.

Verification
REQ-033 WAIT_CYCLES=2: store word 0xDEADBEEF @0x010, then load word @0x010 -> resp_valid 4 edges after each accept; load resp_rdata=0xDEADBEEF, resp_err=0.
REQ-034 After REQ-033, store byte 0x55 @0x011, then load word @0x010 -> 0xDEAD55EF; load half @0x012 -> 0x0000DEAD; load byte @0x013 -> 0x000000DE.
REQ-035 Store half @0x021 and load word @0x022 -> both resp_err=1; load resp_rdata=0; word @0x020 unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0; a req_valid pulse during this time is not accepted.
REQ-037 Assert reset in the first BUSY cycle of a store of 0x12345678 @0x030 -> outputs zero immediately; a subsequent load @0x030 returns the prior contents.
REQ-038 WAIT_CYCLES=0: accept -> resp_valid on the 2nd edge; with resp_ready held high, the next accept occurs 1 cycle after the handshake.
